// File: rtl/udp_pkg.sv
// udp_pkg: shared constants, state encoding and byte-pick helper for the UDP transmitter
package udp_pkg;
  localparam logic [15:0] ETH_TYPE = 16'h0800;
  localparam logic [7:0] UDP_TYPE = 8'd17;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [15:0] MIN_PAYLOAD = 16'd18;
  localparam logic [15:0] MAX_PAYLOAD = 16'd1472;
  localparam logic [7:0] IP_TTL = 8'd64;
  typedef enum logic [8:0] {
    st_idle       = 9'b000000001,
    st_check_sum  = 9'b000000010,
    st_preamble   = 9'b000000100,
    st_eth_header = 9'b000001000,
    st_ip_header  = 9'b000010000,
    st_udp_header = 9'b000100000,
    st_tx_data    = 9'b001000000,
    st_crc        = 9'b010000000,
    st_ifg        = 9'b100000000
  } state_t;
  // Byte i of a left-aligned 160-bit header image, most significant byte first.
  function automatic logic [7:0] pick(input logic [159:0] v, input logic [4:0] i);
    return 8'(v >> (8'd152 - {i, 3'd0}));
  endfunction
endpackage

// File: rtl/udp_tx_crc32_d8.sv
// crc32_d8: byte-wide reflected Ethernet CRC32 register
module crc32_d8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data,
  input  logic        crc_en,
  input  logic        crc_clr,
  output logic [31:0] crc_data
);
  logic [31:0] crc_n;
  // Advance the CRC by eight data bits, LSB first.
  always_comb begin
    crc_n = crc_data;
    for (int i = 0; i < 8; i++)
      crc_n = (crc_n >> 1) ^ ((crc_n[0] ^ data[i]) ? 32'hEDB88320 : 32'h0);
  end
  // Hold, clear to all-ones, or absorb one byte.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc_data <= '1;
    else crc_data <= crc_clr ? '1 : crc_en ? crc_n : crc_data;
endmodule

// File: rtl/udp_tx.sv
// udp_tx: GMII UDP/IPv4 frame transmitter with IP checksum and Ethernet FCS
module udp_tx
  import udp_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd0, 8'd2},
  parameter logic [15:0] BOARD_PORT = 16'd1234,
  parameter logic [15:0] DES_PORT   = 16'd1234,
  parameter int          IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start_en,
  input  logic [15:0] tx_byte_num,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  input  logic [7:0]  tx_data,
  output logic        tx_req,
  output logic        tx_done,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd
);
  state_t state, state_n;
  logic [15:0] cnt, cnt_n, span, len, ident, csum, data_len, total_len, udp_len;
  logic [47:0] mac;
  logic [31:0] ip, sum, sum_full, crc;
  logic [159:0] eth_v, ip_v, udp_v;
  logic [7:0] byte_c, crc_b;
  logic last, start_ok, en_c, req_c, done_c, crc_en;

  assign start_ok  = tx_start_en && tx_byte_num != 16'd0 && tx_byte_num <= MAX_PAYLOAD;
  assign data_len  = len < MIN_PAYLOAD ? MIN_PAYLOAD : len;
  assign total_len = len + 16'd28;
  assign udp_len   = len + 16'd8;
  assign eth_v     = {mac, BOARD_MAC, ETH_TYPE, 48'd0};
  assign ip_v      = {8'h45, 8'h00, total_len, ident, 16'h4000, IP_TTL, UDP_TYPE, csum, BOARD_IP, ip};
  assign udp_v     = {BOARD_PORT, DES_PORT, udp_len, 16'h0000, 96'd0};
  assign sum_full  = 32'h4500 + {16'd0, total_len} + {16'd0, ident} + 32'h4000 + {16'd0, IP_TTL, UDP_TYPE}
                   + {16'd0, BOARD_IP[31:16]} + {16'd0, BOARD_IP[15:0]} + {16'd0, ip[31:16]} + {16'd0, ip[15:0]};
  assign crc_b     = cnt[1:0] == 2'd0 ? crc[7:0] : cnt[1:0] == 2'd1 ? crc[15:8] : cnt[1:0] == 2'd2 ? crc[23:16] : crc[31:24];
  assign crc_en    = state == st_eth_header || state == st_ip_header || state == st_udp_header || state == st_tx_data;
  assign en_c      = state == st_preamble || crc_en || state == st_crc;
  assign done_c    = state == st_ifg && cnt == 16'd0;
  // FIFO read leads the wire by two cycles, so requests start at the last two UDP header bytes.
  assign req_c     = (state == st_udp_header && (cnt == 16'd6 || (cnt == 16'd7 && len >= 16'd2)))
                  || (state == st_tx_data && ({1'b0, cnt} + 17'd2 < {1'b0, len}));

  crc32_d8 u_crc (
    .clk(clk), .rst_n(rst_n), .data(byte_c), .crc_en(crc_en),
    .crc_clr(state == st_preamble), .crc_data(crc)
  );

  // Each state lasts span cycles and then steps to the next one-hot state.
  always_comb begin
    span = state == st_check_sum ? 16'd3 : state == st_preamble ? 16'd8 : state == st_eth_header ? 16'd14 :
           state == st_ip_header ? 16'd20 : state == st_udp_header ? 16'd8 : state == st_tx_data ? data_len :
           state == st_crc ? 16'd4 : state == st_ifg ? 16'(IFG_CYCLES) : 16'd1;
    last = cnt == span - 16'd1;
    state_n = state == st_idle ? (start_ok ? st_check_sum : st_idle) : !last ? state :
              state == st_ifg ? st_idle : state_t'(state << 1);
    cnt_n = (state == st_idle || last) ? 16'd0 : cnt + 16'd1;
  end

  // Byte to put on the wire next cycle.
  always_comb begin
    byte_c = state == st_preamble ? (cnt == 16'd7 ? SFD_BYTE : PREAMBLE_BYTE) :
             state == st_eth_header ? pick(eth_v, cnt[4:0]) :
             state == st_ip_header ? pick(ip_v, cnt[4:0]) :
             state == st_udp_header ? pick(udp_v, cnt[4:0]) :
             state == st_tx_data ? (cnt < len ? tx_data : 8'd0) :
             state == st_crc ? ~crc_b : 8'd0;
  end

  // Control state, latched request fields, three-step checksum and IP ident.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= st_idle;
      cnt   <= '0;
      len   <= '0;
      mac   <= '0;
      ip    <= '0;
      sum   <= '0;
      csum  <= '0;
      ident <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == st_idle && start_ok) begin
        len <= tx_byte_num;
        mac <= des_mac;
        ip  <= des_ip;
      end
      if (state == st_check_sum) sum <= cnt == 16'd0 ? sum_full : {16'd0, sum[31:16]} + {16'd0, sum[15:0]};
      if (state == st_check_sum && cnt == 16'd2) csum <= ~(sum[31:16] + sum[15:0]);
      if (done_c) ident <= ident + 16'd1;
    end

  // Registered GMII and FIFO-side outputs.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gmii_tx_en <= 1'b0;
      gmii_txd   <= '0;
      tx_req     <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      gmii_tx_en <= en_c;
      gmii_txd   <= byte_c;
      tx_req     <= req_c;
      tx_done    <= done_c;
    end
endmodule
